// File: rtl/txe_pkg.sv
// Shared encodings for the transmit packet memory reader.
package txe_pkg;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StFetch = 2'd1;
  localparam logic [1:0] StSend  = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  // Minimum Ethernet frame length (without CRC) used when padding is built in.
  localparam int unsigned TXE_MINLEN = 60;

endpackage

// File: rtl/txeread_if.sv
// Command, memory-read and byte-stream signals of the transmit packet reader.
interface txeread_if #(
  parameter int unsigned AW = 12
);
  logic          i_ce;
  logic          i_cmd;
  logic [AW+1:0] i_len;
  logic          o_busy;
  logic          o_rd;
  logic [AW-1:0] o_raddr;
  logic [31:0]   i_rdata;
  logic          o_v;
  logic [7:0]    o_d;

  modport master (
    input  i_ce, i_cmd, i_len, i_rdata,
    output o_busy, o_rd, o_raddr, o_v, o_d
  );

  modport slave (
    output i_ce, i_cmd, i_len, i_rdata,
    input  o_busy, o_rd, o_raddr, o_v, o_d
  );
endinterface

// File: rtl/txeserial.sv
// Word-to-byte lane shifter: current word in sreg, prefetched next word in nbuf.
module txeserial (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        capture,
  input  logic        shift,
  input  logic        reload,
  input  logic [31:0] rdata,
  output logic [7:0]  top_byte
);

  logic [31:0] sreg_q;
  logic [31:0] nbuf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg_q <= '0;
      nbuf_q <= '0;
    end else begin
      if (load) begin
        sreg_q <= rdata;
      end else if (reload) begin
        sreg_q <= nbuf_q;
      end else if (shift) begin
        sreg_q <= {sreg_q[23:0], 8'h00};
      end
      if (capture) begin
        nbuf_q <= rdata;
      end
    end
  end

  assign top_byte = sreg_q[31:24];

endmodule

// File: rtl/txeread.sv
// Transmit packet memory reader: fetches 32-bit words and emits bytes MSB first on i_ce.
// Define TXEREAD_PAD_EN to zero-pad short packets up to TXE_MINLEN bytes.
module txeread
  import txe_pkg::*;
#(
  parameter int unsigned AW = 12
) (
  input logic        i_clk,
  input logic        i_reset,
  txeread_if.master  bus
);

  localparam int unsigned LW = AW + 2;

  logic [1:0]    state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          rd_q, rd_d;
  logic [AW-1:0] raddr_q, raddr_d;
  logic          rvalid_q;
  logic          v_q, v_d;
  logic [7:0]    d_q, d_d;
  logic          load, capture, shift, reload;
  logic [7:0]    top_byte, byte_out;
  logic [LW-1:0] last_idx;
  logic [LW:0]   next_byte;

  // One extra bit so the word after the last addressable word compares correctly.
  assign next_byte = {1'b0, cnt_q[LW-1:2], 2'b00} + (LW+1)'(4);

`ifdef TXEREAD_PAD_EN
  logic [LW-1:0] tot_q, tot_d;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) tot_q <= '0;
    else         tot_q <= tot_d;
  end

  assign last_idx = tot_q - LW'(1);
  assign byte_out = (cnt_q < len_q) ? top_byte : 8'h00;
`else
  assign last_idx = len_q - LW'(1);
  assign byte_out = top_byte;
`endif

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    rd_d    = 1'b0;
    raddr_d = raddr_q;
    v_d     = v_q;
    d_d     = d_q;
    load    = 1'b0;
    capture = 1'b0;
    shift   = 1'b0;
    reload  = 1'b0;
`ifdef TXEREAD_PAD_EN
    tot_d   = tot_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.i_cmd && (bus.i_len != '0)) begin
          len_d   = bus.i_len;
`ifdef TXEREAD_PAD_EN
          tot_d   = (bus.i_len < LW'(TXE_MINLEN)) ? LW'(TXE_MINLEN) : bus.i_len;
`endif
          cnt_d   = '0;
          busy_d  = 1'b1;
          rd_d    = 1'b1;
          raddr_d = '0;
          state_d = StFetch;
        end
      end
      StFetch: begin
        if (rvalid_q) begin
          load    = 1'b1;
          state_d = StSend;
        end
      end
      StSend: begin
        capture = rvalid_q;
        if (bus.i_ce) begin
          v_d   = 1'b1;
          d_d   = byte_out;
          cnt_d = cnt_q + LW'(1);
          // Prefetch the next word as the first byte of the current one goes out.
          if ((cnt_q[1:0] == 2'd0) && (next_byte < {1'b0, len_q})) begin
            rd_d    = 1'b1;
            raddr_d = next_byte[LW-1:2];
          end
          if (cnt_q[1:0] == 2'd3) reload = 1'b1;
          else                    shift  = 1'b1;
          if (cnt_q == last_idx) state_d = StDone;
        end
      end
      StDone: begin
        if (bus.i_ce) begin
          v_d     = 1'b0;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= StIdle;
      len_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      rd_q     <= 1'b0;
      raddr_q  <= '0;
      rvalid_q <= 1'b0;
      v_q      <= 1'b0;
      d_q      <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      rd_q     <= rd_d;
      raddr_q  <= raddr_d;
      rvalid_q <= rd_q;
      v_q      <= v_d;
      d_q      <= d_d;
    end
  end

  txeserial u_serial (
    .clk      (i_clk),
    .rst      (i_reset),
    .load     (load),
    .capture  (capture),
    .shift    (shift),
    .reload   (reload),
    .rdata    (bus.i_rdata),
    .top_byte (top_byte)
  );

  assign bus.o_busy  = busy_q;
  assign bus.o_rd    = rd_q;
  assign bus.o_raddr = raddr_q;
  assign bus.o_v     = v_q;
  assign bus.o_d     = d_q;

endmodule
